// File: rtl/seg7_time_display.sv
// HH:MM driver for a 4-digit multiplexed common-anode 7-segment display.
// Inputs are captured once per frame so the four digits never tear.
module seg7_time_display #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 50_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       display_en,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [1:0] D0 = 2'd0;
  localparam logic [1:0] D1 = 2'd1;
  localparam logic [1:0] D2 = 2'd2;
  localparam logic [1:0] D3 = 2'd3;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'd0:    font = 7'h40;
      4'd1:    font = 7'h79;
      4'd2:    font = 7'h24;
      4'd3:    font = 7'h30;
      4'd4:    font = 7'h19;
      4'd5:    font = 7'h12;
      4'd6:    font = 7'h02;
      4'd7:    font = 7'h78;
      4'd8:    font = 7'h00;
      4'd9:    font = 7'h10;
      default: font = SEG_DASH;
    endcase
  endfunction

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          colon_q, colon_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic          lit_q, lit_d;
  logic [3:0]    sh_hr_q, sh_hr_d;
  logic [5:0]    sh_min_q, sh_min_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          slot_tick, blink_wrap, hr_bad, min_bad;
  logic [3:0]    min_ones, min_tens, hr_ones;
  logic [6:0]    digit_seg;

  // Decode of the digit the FSM is about to light, from the shadow copy only.
  always_comb begin
    hr_bad   = (sh_hr_q == 4'd0) || (sh_hr_q > 4'd12);
    min_bad  = sh_min_q > 6'd59;
    min_ones = 4'(sh_min_q % 6'd10);
    min_tens = 4'(sh_min_q / 6'd10);
    hr_ones  = (sh_hr_q >= 4'd10) ? sh_hr_q - 4'd10 : sh_hr_q;
    case (state_q)
      D0:      digit_seg = min_bad ? SEG_DASH : font(min_ones);
      D1:      digit_seg = min_bad ? SEG_DASH : font(min_tens);
      D2:      digit_seg = hr_bad ? SEG_DASH : font(hr_ones);
      default: digit_seg = hr_bad ? SEG_DASH : ((sh_hr_q >= 4'd10) ? font(4'd1) : SEG_BLANK);
    endcase
  end

  always_comb begin
    slot_tick     = refresh_cnt_q == REF_LAST;
    refresh_cnt_d = slot_tick ? '0 : refresh_cnt_q + RW'(1);
    blink_wrap    = blink_cnt_q == BLK_LAST;
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    colon_d       = blink_wrap ? ~colon_q : colon_q;

    state_d = state_q;
    if (slot_tick) begin
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        D2:      state_d = D3;
        default: state_d = D0;
      endcase
    end

    // Capture on the D3->D0 step; the D3 slot itself still decodes the old copy.
    sh_hr_d  = sh_hr_q;
    sh_min_d = sh_min_q;
    if (slot_tick && state_q == D3) begin
      sh_hr_d  = hours;
      sh_min_d = minutes;
    end

    cur_d = slot_tick ? state_q : cur_q;
    lit_d = lit_q | slot_tick;
    seg_d = slot_tick ? digit_seg : seg_q;
    an_d  = (display_en && lit_d) ? ~(4'b0001 << cur_d) : 4'b1111;
    dp_d  = ~(display_en && lit_d && (cur_d == D2) && colon_d);
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      colon_q       <= 1'b1;
      state_q       <= D0;
      cur_q         <= D0;
      lit_q         <= 1'b0;
      sh_hr_q       <= 4'd12;
      sh_min_q      <= 6'd0;
      seg_q         <= SEG_BLANK;
      an_q          <= 4'b1111;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      colon_q       <= colon_d;
      state_q       <= state_d;
      cur_q         <= cur_d;
      lit_q         <= lit_d;
      sh_hr_q       <= sh_hr_d;
      sh_min_q      <= sh_min_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_time_display.sv
// Bench for seg7_time_display with short dividers; the reference model works
// from elapsed clock count since reset and decimal digit arithmetic.
module tb_seg7_time_display;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       display_en;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks = 0;
  int failures = 0;

  seg7_time_display #(.REFRESH_DIV(4), .BLINK_DIV(32)) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .display_en(display_en),
    .hours(hours), .minutes(minutes), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] FONT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state: n = edges since reset release, slot = n/4 clocks.
  int         n;
  int         sh_h, sh_m, m_cur;
  bit         m_lit, m_colon;
  logic [6:0] m_seg;
  logic [3:0] exp_an;
  logic       exp_dp;

  function automatic logic [6:0] dig_seg(int d, int h, int m);
    bit hb = (h == 0) || (h > 12);
    bit mb = m > 59;
    case (d)
      0:       return mb ? 7'h3F : FONT[m % 10];
      1:       return mb ? 7'h3F : FONT[m / 10];
      2:       return hb ? 7'h3F : FONT[h % 10];
      default: return hb ? 7'h3F : ((h >= 10) ? FONT[1] : 7'h7F);
    endcase
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      n = 0; sh_h = 12; sh_m = 0; m_cur = 0; m_lit = 0; m_colon = 1;
      m_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
    end else begin
      n++;
      if (n % 4 == 0) begin
        m_cur = ((n / 4) - 1) % 4;
        m_seg = dig_seg(m_cur, sh_h, sh_m);
        m_lit = 1;
        if (m_cur == 3) begin sh_h = int'(hours); sh_m = int'(minutes); end
      end
      m_colon = ((n / 32) % 2) == 0;
      exp_an = 4'hF;
      if (display_en && m_lit) exp_an[m_cur] = 1'b0;
      exp_dp = !(display_en && m_lit && m_cur == 2 && m_colon);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; display_en = 1; hours = 4'd9; minutes = 6'd47;
    repeat (3) begin
      tick();
      checks++;
      if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
        failures++;
        $display("FAIL reset_hold got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
      end
    end
    reset_n = 1;
    repeat (3) tick();
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL reset_blank got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    tick();
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'h40, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_digit got an=%b seg=%h dp=%b want an=1110 seg=40 dp=1", an, seg, dp);
    end
  endtask

  // 9:47 is captured at n=16; its frame is shown from n=20..35.
  task automatic test_frame_947();
    logic [3:0] t_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] t_seg [4] = '{7'h78, 7'h19, 7'h10, 7'h7F};
    repeat (36) begin
      tick();
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL frame_947 n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
      if (n >= 20 && n < 36) begin
        checks++;
        if (an !== t_an[(n - 20) / 4] || seg !== t_seg[(n - 20) / 4]) begin
          failures++;
          $display("FAIL frame_947_const n=%0d got an=%b seg=%h want an=%b seg=%h",
                   n, an, seg, t_an[(n - 20) / 4], t_seg[(n - 20) / 4]);
        end
      end
    end
  endtask

  task automatic test_colon_1205();
    int dp_lows = 0;
    hours = 4'd12; minutes = 6'd5;
    repeat (80) begin
      tick();
      if (dp === 1'b0) dp_lows++;
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL colon_1205 n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
    end
    checks++;
    if (dp_lows == 0) begin
      failures++;
      $display("FAIL colon_seen got dp_low_cycles=%0d want >0", dp_lows);
    end
  endtask

  task automatic test_invalid();
    hours = 4'd0; minutes = 6'd60;
    repeat (40) begin
      tick();
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL invalid n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
    end
    // Last 16 cycles are a full frame of the captured 0:60 value.
    checks++;
    if (seg !== 7'h3F) begin
      failures++;
      $display("FAIL invalid_dash got seg=%h want 3f", seg);
    end
  endtask

  task automatic test_midframe_change();
    int guard = 0;
    hours = 4'd9; minutes = 6'd47;
    repeat (32) tick();
    while (n % 16 != 12 && guard < 64) begin tick(); guard++; end
    checks++;
    if (guard >= 64) begin
      failures++;
      $display("FAIL midframe_align got guard=%0d want <64", guard);
    end
    minutes = 6'd48;
    repeat (24) begin
      tick();
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL midframe n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
      if (n % 16 == 4 || n % 16 == 12) begin
        checks++;
        if (seg !== ((n % 16 == 4) ? 7'h00 : 7'h10)) begin
          failures++;
          $display("FAIL midframe_const n=%0d got seg=%h want %h", n, seg,
                   (n % 16 == 4) ? 7'h00 : 7'h10);
        end
      end
    end
  endtask

  task automatic test_display_en();
    repeat (7) tick();
    display_en = 0;
    repeat (10) begin
      tick();
      checks++;
      if ({an, dp} !== 5'b11111 || {an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL disp_off n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
    end
    display_en = 1;
    repeat (20) begin
      tick();
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL disp_resume n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    hours = 4'd3; minutes = 6'd21;
    repeat (6) tick();
    reset_n = 0;
    repeat (2) tick();
    reset_n = 1;
    repeat (40) begin
      tick();
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL reset_mid n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) begin
        hours   = 4'($urandom_range(0, 15));
        minutes = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 15) == 0) display_en = ~display_en;
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
      checks++;
      if ({an, seg, dp} !== {exp_an, m_seg, exp_dp}) begin
        failures++;
        $display("FAIL random n=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, m_seg, exp_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_947();
    test_colon_1205();
    test_invalid();
    test_midframe_change();
    test_display_en();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
